// File: rtl/cfg_vpd_loader.sv
// Configuration VPD loader: after reset (or on reload_req) reads a checksummed
// image over the VPD word interface and commits it to the cfg_func0/cfg_func1 fields.
//
// state | meaning
// IDLE  | load finished, committed values valid (cfg_ready)
// REQ   | launch read of image word idx
// WAIT  | rd_req held until rd_ack or the per-word timer expires
// CHECK | validate magic, descriptor ranges and checksum; commit on success
// FAIL  | restore parameter defaults and publish the failure status
module cfg_vpd_loader #(
    parameter int          NUM_AFU         = 1,
    parameter logic [23:0] BASE_ADDR       = 24'h000000,
    parameter int          TIMEOUT         = 1024,
    parameter logic [15:0] DFLT_SUBSYS_ID  = 16'h0667,
    parameter logic [15:0] DFLT_SUBSYS_VID = 16'h1014,
    parameter logic [63:0] DFLT_SERIAL     = 64'hDEAD_DEAD_DEAD_DEAD,
    parameter int          DFLT_BAR0_LOG2  = 26,
    parameter logic [4:0]  DFLT_PASID_W    = 5'd9
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   reload_req,
    output logic                   rd_req,
    output logic [23:0]            rd_addr,
    input  logic                   rd_ack,
    input  logic [31:0]            rd_data,
    output logic                   cfg_ready,
    output logic [1:0]             load_status,
    output logic [15:0]            f0_ro_csh_subsystem_id,
    output logic [15:0]            f0_ro_csh_subsystem_vendor_id,
    output logic [63:0]            f0_ro_dsn_serial_number,
    output logic [64*NUM_AFU-1:0]  f1_ro_csh_mmio_bar0_size,
    output logic [5*NUM_AFU-1:0]   f1_ro_pasid_max_pasid_width,
    output logic [12*NUM_AFU-1:0]  f1_ro_octrl_actag_len_supported,
    output logic [8*NUM_AFU-1:0]   f1_ro_octrl_reset_duration,
    output logic                   f1_ro_ofunc_afu_present,
    output logic [4:0]             f1_ro_ofunc_max_afu_index
);
    localparam int              NW         = NUM_AFU + 5;
    localparam logic [31:0]     MAGIC      = 32'h4F43_5644;
    localparam int              TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TIMER_LOAD = TW'(TIMEOUT - 2);
    localparam logic [63:0]     DFLT_BAR0  = 64'hFFFF_FFFF_FFFF_FFFF << DFLT_BAR0_LOG2;

    localparam logic [64*NUM_AFU-1:0] DFLT_BAR0_V  = {NUM_AFU{DFLT_BAR0}};
    localparam logic [5*NUM_AFU-1:0]  DFLT_PASID_V = {NUM_AFU{DFLT_PASID_W}};
    localparam logic [12*NUM_AFU-1:0] DFLT_ACTAG_V = {NUM_AFU{12'h020}};
    localparam logic [8*NUM_AFU-1:0]  DFLT_RDUR_V  = {NUM_AFU{8'h10}};

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK, S_FAIL} state_t;

    state_t               state, state_nxt;
    logic [3:0]           idx;
    logic [TW-1:0]        timer;
    logic [31:0]          csum;
    logic [31:0]          shadow [NW];
    logic [1:0]           fail_code;
    logic [NUM_AFU-1:0]   afu_present;
    logic                 last_word;
    logic                 bad_field;
    logic                 bad_csum;

    assign last_word = (idx == 4'(NW - 1));
    assign bad_csum  = (shadow[NW-1] != csum);
    assign cfg_ready = (state == S_IDLE);

    assign f1_ro_ofunc_afu_present   = |afu_present;
    assign f1_ro_ofunc_max_afu_index = 5'(NUM_AFU - 1);

    always_comb begin
        bad_field = (shadow[0] != MAGIC);
        for (int i = 0; i < NUM_AFU; i++) begin
            if ((shadow[4+i][31:26] < 6'd20) || (shadow[4+i][31:26] > 6'd40) ||
                (shadow[4+i][25:21] > 5'd20))
                bad_field = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_REQ;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (reload_req) state_nxt = S_REQ;
            S_REQ:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (rd_ack)             state_nxt = last_word ? S_CHECK : S_REQ;
                else if (timer == '0)   state_nxt = S_FAIL;
            end
            S_CHECK: state_nxt = (bad_field || bad_csum) ? S_FAIL : S_IDLE;
            S_FAIL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_req                          <= 1'b0;
            rd_addr                         <= '0;
            idx                             <= '0;
            timer                           <= '0;
            csum                            <= '0;
            fail_code                       <= 2'b00;
            load_status                     <= 2'b00;
            for (int k = 0; k < NW; k++) shadow[k] <= '0;
            f0_ro_csh_subsystem_id          <= DFLT_SUBSYS_ID;
            f0_ro_csh_subsystem_vendor_id   <= DFLT_SUBSYS_VID;
            f0_ro_dsn_serial_number         <= DFLT_SERIAL;
            f1_ro_csh_mmio_bar0_size        <= DFLT_BAR0_V;
            f1_ro_pasid_max_pasid_width     <= DFLT_PASID_V;
            f1_ro_octrl_actag_len_supported <= DFLT_ACTAG_V;
            f1_ro_octrl_reset_duration      <= DFLT_RDUR_V;
            afu_present                     <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (reload_req) begin
                        idx         <= '0;
                        load_status <= 2'b00;
                    end
                end
                S_REQ: begin
                    rd_req  <= 1'b1;
                    rd_addr <= BASE_ADDR + 24'(idx);
                    timer   <= TIMER_LOAD;
                end
                S_WAIT: begin
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        idx    <= idx + 4'd1;
                        for (int k = 0; k < NW; k++)
                            if (idx == 4'(k)) shadow[k] <= rd_data;
                        // checksum word itself is kept out of the running XOR
                        if (!last_word)
                            csum <= (idx == 4'd0) ? rd_data : (csum ^ rd_data);
                    end else if (timer == '0) begin
                        rd_req    <= 1'b0;
                        fail_code <= 2'b11;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (bad_field) begin
                        fail_code <= 2'b10;
                    end else if (bad_csum) begin
                        fail_code <= 2'b11;
                    end else begin
                        load_status                   <= 2'b01;
                        f0_ro_csh_subsystem_vendor_id <= shadow[1][31:16];
                        f0_ro_csh_subsystem_id        <= shadow[1][15:0];
                        f0_ro_dsn_serial_number       <= {shadow[2], shadow[3]};
                        for (int i = 0; i < NUM_AFU; i++) begin
                            f1_ro_csh_mmio_bar0_size[64*i +: 64] <=
                                64'hFFFF_FFFF_FFFF_FFFF << shadow[4+i][31:26];
                            f1_ro_pasid_max_pasid_width[5*i +: 5]      <= shadow[4+i][25:21];
                            f1_ro_octrl_actag_len_supported[12*i +: 12] <= shadow[4+i][20:9];
                            f1_ro_octrl_reset_duration[8*i +: 8]       <= shadow[4+i][8:1];
                            afu_present[i]                             <= shadow[4+i][0];
                        end
                    end
                end
                S_FAIL: begin
                    load_status                     <= fail_code;
                    f0_ro_csh_subsystem_id          <= DFLT_SUBSYS_ID;
                    f0_ro_csh_subsystem_vendor_id   <= DFLT_SUBSYS_VID;
                    f0_ro_dsn_serial_number         <= DFLT_SERIAL;
                    f1_ro_csh_mmio_bar0_size        <= DFLT_BAR0_V;
                    f1_ro_pasid_max_pasid_width     <= DFLT_PASID_V;
                    f1_ro_octrl_actag_len_supported <= DFLT_ACTAG_V;
                    f1_ro_octrl_reset_duration      <= DFLT_RDUR_V;
                    afu_present                     <= '1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cfg_vpd_loader.md
Name: cfg_vpd_loader

Overview:
- Parametrised successor to the fixed configuration tie-offs. Drives the same read-only fields into cfg_func0/cfg_func1, for 1..MAX_AFU AFUs.
- After reset, loads card-specific and per-AFU values from an external 32-bit VPD/flash word interface.
- Validates the image (magic, field range, checksum). Commits it atomically, or falls back to parameter defaults.
- Sits between the flash/VPD controller and cfg_func0/cfg_func1. Outputs are static once cfg_ready is high.

Parameters:
NUM_AFU, 1, number of AFU descriptor words loaded (1..4)
BASE_ADDR, 24'h000000, VPD word address of the image header
TIMEOUT, 1024, max cycles waiting for rd_ack per word (>=2)
DFLT_SUBSYS_ID, 16'h0667, default f0/f1 subsystem id
DFLT_SUBSYS_VID, 16'h1014, default f0/f1 subsystem vendor id
DFLT_SERIAL, 64'hDEAD_DEAD_DEAD_DEAD, default DSN serial number
DFLT_BAR0_LOG2, 26, default per-AFU BAR0 size log2 (64 MB)
DFLT_PASID_W, 5'd9, default per-AFU max PASID width

Ports:
clock  in  1  core clock
reset_n  in  1  asynchronous active-low reset
reload_req  in  1  single-cycle pulse: re-run load
rd_req  out  1  VPD word read request, held until rd_ack
rd_addr  out  24  word address, stable while rd_req
rd_ack  in  1  single-cycle: rd_data valid
rd_data  in  32  read word
cfg_ready  out  1  committed values valid, load finished
load_status  out  2  00 busy, 01 image loaded, 10 default: bad magic/field, 11 default: timeout/checksum
f0_ro_csh_subsystem_id  out  16  committed subsystem id
f0_ro_csh_subsystem_vendor_id  out  16  committed vendor id
f0_ro_dsn_serial_number  out  64  committed serial
f1_ro_csh_mmio_bar0_size  out  64*NUM_AFU  per-AFU BAR0 size mask, AFU i at [64i+63:64i]
f1_ro_pasid_max_pasid_width  out  5*NUM_AFU  per-AFU max PASID width
f1_ro_octrl_actag_len_supported  out  12*NUM_AFU  per-AFU acTag length
f1_ro_octrl_reset_duration  out  8*NUM_AFU  per-AFU reset duration
f1_ro_ofunc_afu_present  out  1  OR of per-AFU present bits
f1_ro_ofunc_max_afu_index  out  5  NUM_AFU-1 constant

Behaviour:
- Image layout is NW = NUM_AFU+5 words at BASE_ADDR+k:
  - w0: magic 32'h4F43_5644.
  - w1: {vendor_id[31:16], subsys_id[15:0]}.
  - w2: serial[63:32]. w3: serial[31:0].
  - w4..w(3+NUM_AFU): AFU descriptor = {bar0_log2[31:26], pasid_w[25:21], actag_len[20:9], reset_dur[8:1], present[0]}.
  - Last word: checksum = XOR of w0..w(NW-2).
- Reset values:
  - Committed registers = defaults. Defaults per AFU: actag 12'h020, reset_dur 8'h10, present 1.
  - BAR0 default mask = ~((1<<DFLT_BAR0_LOG2)-1).
  - rd_req=0, rd_addr=0, cfg_ready=0, load_status=00.
  - FSM enters REQ on the first cycle after reset_n deasserts.
- FSM states:
  - IDLE (done): from here, reload_req -> REQ, with cfg_ready=0 and load_status=00.
  - REQ: rd_req=1, rd_addr=BASE_ADDR+idx, timer cleared -> WAIT.
  - WAIT: rd_req held high.
    - rd_ack: capture word into shadow, XOR into running checksum (except last word), rd_req=0 next cycle. Then idx++ -> REQ, or -> CHECK when idx==NW-1.
    - Timer reaches TIMEOUT-1 without ack -> FAIL with status 11.
  - CHECK: one cycle.
    - Magic mismatch, or any descriptor with bar0_log2 outside 20..40, or pasid_w>20 -> FAIL status 10.
    - Else checksum mismatch -> FAIL status 11.
    - Else commit all shadow fields to output registers in one cycle, status 01 -> IDLE.
  - FAIL: load defaults into the committed registers in one cycle -> IDLE with the recorded status.
- Magic is checked at CHECK only. All NW words are always read unless a timeout occurs.
- cfg_ready=1 exactly when in IDLE after at least one completed load.
- Outputs hold their previously committed values throughout a reload. They change only in the commit/FAIL cycle, and cfg_ready rises the cycle after.
- BAR0 mask = 64'hFFFF_FFFF_FFFF_FFFF << bar0_log2.
- reload_req is ignored while not in IDLE.
- rd_ack while not in WAIT is ignored.
- rd_ack in the first WAIT cycle is accepted. Minimum 2 cycles per word.
- reset_n assertion at any point aborts immediately: all state returns to reset values and the load restarts from w0.

Test Plan:
- NUM_AFU=2, valid image (vid 1014/sid 0668, serial 0123_4567_89AB_CDEF, AFU0 log2=26 pasid 9, AFU1 log2=20 pasid 0), ack latency 1 -> 7 reads at addr 0..6. Then status 01, cfg_ready=1, AFU0 BAR0 FFFF_FFFF_FC00_0000, AFU1 BAR0 FFFF_FFFF_FFF0_0000, subsystem id 0668.
- w0=0 -> all 7 words still read. Then status 10 and outputs = defaults (subsys 0667, serial DEAD_DEAD_DEAD_DEAD).
- Valid image with checksum word bit 0 flipped -> status 11, defaults, cfg_ready=1.
- TIMEOUT=16, no ack on w2 -> FAIL 16 cycles after the REQ for addr 2. rd_req drops, status 11.
- After a good load, reload_req with an image having serial 1 -> outputs keep the old serial while cfg_ready=0, then switch to 1 in the commit cycle. A second reload_req mid-load is ignored.
- reset_n pulsed low during w3 WAIT -> outputs return to defaults asynchronously. After release, reads restart at BASE_ADDR.
